// File: rtl/tpu_cmd_sequencer.sv
// tpu_cmd_sequencer: Avalon-MM master that runs one complete TPU multiply job
// (RESET, FILL_FIFO, DRAIN_FIFO, MULTIPLY with done-bit polling), then reads
// the result rows back and streams them out over a valid/ready port.
// Optional build macro SEQ_TIMEOUT_EN bounds each polling phase to
// TIMEOUT_POLLS completed reads and flags a sticky error when it runs out.
module tpu_cmd_sequencer #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 10,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              weight_base,
    input  logic [7:0]              input_base,
    input  logic [7:0]              output_base,
    input  logic [8:0]              num_rows,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_read,
    output logic                    master_write,
    output logic [DATA_WIDTH-1:0]   master_writedata,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]   master_readdata,
    input  logic                    master_waitrequest,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [7:0]              out_row,
    input  logic                    out_ready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_RST,
        S_WR_FILL,
        S_POLL_FILL,
        S_WR_DRAIN,
        S_POLL_DRAIN,
        S_WR_MUL,
        S_POLL_MUL,
        S_POLL_GAP,
        S_RD_ROW,
        S_PUSH,
        S_DONE
    } state_t;

    // A zero poll budget would give up before the first status read.
    if (TIMEOUT_POLLS < 1) begin : g_badTimeoutPolls
        $error("TIMEOUT_POLLS must be at least 1");
    end

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_weightBase;
    logic [7:0]  r_inputBase;
    logic [7:0]  r_outputBase;
    logic [8:0]  r_numRows;
    logic [7:0]  r_row;
    logic [1:0]  r_pollPhase;
    logic [DATA_WIDTH-1:0] r_outData;

    logic        w_xferOk;
    logic        w_isPoll;
    logic        w_pollRead;
    logic        w_pollBit;
    logic        w_timeout;
    logic        w_lastRow;
    logic        w_wrCmdDone;
    logic [7:0]  w_rowIdx;

    assign w_xferOk    = ~master_waitrequest;
    assign w_isPoll    = (r_state == S_POLL_FILL) || (r_state == S_POLL_DRAIN) ||
                         (r_state == S_POLL_MUL);
    assign w_pollRead  = w_isPoll & w_xferOk;
    assign w_wrCmdDone = w_xferOk & ((r_state == S_WR_FILL) || (r_state == S_WR_DRAIN) ||
                                     (r_state == S_WR_MUL));
    assign w_rowIdx    = r_outputBase + r_row;
    assign w_lastRow   = ({1'b0, r_row} == (r_numRows - 9'd1));

    assign out_data          = r_outData;
    assign out_row           = r_row;
    assign master_byteenable = '1;

    // Select the done bit that belongs to the phase currently being polled.
    always_comb begin
        w_pollBit = 1'b0;
        case (r_state)
            S_POLL_FILL:  w_pollBit = master_readdata[0];
            S_POLL_DRAIN: w_pollBit = master_readdata[1];
            S_POLL_MUL:   w_pollBit = master_readdata[2];
            default:      w_pollBit = 1'b0;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int PCW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;

    logic [PCW-1:0] r_pollCnt;
    logic           r_error;

    assign w_timeout = (r_pollCnt == PCW'(TIMEOUT_POLLS - 1));
    assign error     = r_error;

    // Count completed status reads; restart the count as each poll phase begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pollCnt <= '0;
        end else if (w_wrCmdDone) begin
            r_pollCnt <= '0;
        end else if (w_pollRead && !w_pollBit) begin
            r_pollCnt <= r_pollCnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only when a new job is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_error <= 1'b0;
        end else if (w_pollRead && !w_pollBit && w_timeout) begin
            r_error <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Walk the command sequence; every bus state waits out waitrequest.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_WR_RST;
            S_WR_RST:   if (w_xferOk) w_next = S_WR_FILL;
            S_WR_FILL:  if (w_xferOk) w_next = S_POLL_FILL;
            S_WR_DRAIN: if (w_xferOk) w_next = S_POLL_DRAIN;
            S_WR_MUL:   if (w_xferOk) w_next = S_POLL_MUL;
            S_POLL_FILL, S_POLL_DRAIN, S_POLL_MUL: begin
                if (w_xferOk) begin
                    if (w_pollBit) begin
                        if (r_state == S_POLL_FILL) begin
                            w_next = S_WR_DRAIN;
                        end else if (r_state == S_POLL_DRAIN) begin
                            w_next = S_WR_MUL;
                        end else if (r_numRows == 9'd0) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_RD_ROW;
                        end
                    end else if (w_timeout) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                case (r_pollPhase)
                    2'd0:    w_next = S_POLL_FILL;
                    2'd1:    w_next = S_POLL_DRAIN;
                    default: w_next = S_POLL_MUL;
                endcase
            end
            S_RD_ROW:   if (w_xferOk) w_next = S_PUSH;
            S_PUSH:     if (out_ready) w_next = w_lastRow ? S_DONE : S_RD_ROW;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Bus and status outputs decoded from the current state only, so they are
    // stable for the whole of a stalled transfer.
    always_comb begin
        busy             = (r_state != S_IDLE);
        done             = (r_state == S_DONE);
        out_valid        = (r_state == S_PUSH);
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (r_state)
            S_WR_RST: begin
                master_write          = 1'b1;
                master_writedata[3:0] = 4'hF;
            end
            S_WR_FILL: begin
                master_write           = 1'b1;
                master_writedata[11:0] = {r_weightBase, 4'h1};
            end
            S_WR_DRAIN: begin
                master_write          = 1'b1;
                master_writedata[3:0] = 4'h2;
            end
            S_WR_MUL: begin
                master_write           = 1'b1;
                master_writedata[19:0] = {r_outputBase, r_inputBase, 4'h3};
            end
            S_POLL_FILL, S_POLL_DRAIN, S_POLL_MUL: begin
                master_read = 1'b1;
            end
            S_RD_ROW: begin
                master_read                          = 1'b1;
                master_address[ADDR_WIDTH-1 -: 2]    = 2'b11;
                master_address[7:0]                  = w_rowIdx;
            end
            default: begin
                master_read = 1'b0;
            end
        endcase
    end

    // Job parameters, poll phase tracking, row counter and captured row data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_weightBase <= '0;
            r_inputBase  <= '0;
            r_outputBase <= '0;
            r_numRows    <= '0;
            r_row        <= '0;
            r_pollPhase  <= '0;
            r_outData    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_weightBase <= weight_base;
                        r_inputBase  <= input_base;
                        r_outputBase <= output_base;
                        r_numRows    <= num_rows;
                        r_row        <= '0;
                    end
                end
                S_WR_FILL:  if (w_xferOk) r_pollPhase <= 2'd0;
                S_WR_DRAIN: if (w_xferOk) r_pollPhase <= 2'd1;
                S_WR_MUL:   if (w_xferOk) r_pollPhase <= 2'd2;
                S_RD_ROW:   if (w_xferOk) r_outData <= master_readdata;
                S_PUSH:     if (out_ready) r_row <= r_row + 8'd1;
                default: begin
                    r_row <= r_row;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// tb_tpu_cmd_sequencer: table-driven directed bench for tpu_cmd_sequencer with
// a small behavioural TPU slave (stalls, delayed done bits, row memory).
module tb_tpu_cmd_sequencer;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int TP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    weight_base;
    logic [7:0]    input_base;
    logic [7:0]    output_base;
    logic [8:0]    num_rows;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic          master_write;
    logic [DW-1:0] master_writedata;
    logic [DW/8-1:0] master_byteenable;
    logic [DW-1:0] master_readdata;
    logic          master_waitrequest;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_row;
    logic          out_ready;

    tpu_cmd_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_POLLS(TP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .weight_base(weight_base),
        .input_base(input_base),
        .output_base(output_base),
        .num_rows(num_rows),
        .busy(busy),
        .done(done),
        .error(error),
        .master_address(master_address),
        .master_read(master_read),
        .master_write(master_write),
        .master_writedata(master_writedata),
        .master_byteenable(master_byteenable),
        .master_readdata(master_readdata),
        .master_waitrequest(master_waitrequest),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_row(out_row),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]        wb;
        logic [7:0]        ib;
        logic [7:0]        ob;
        logic [8:0]        nr;
        int                stall;
        int                polls;
        int                bpRow;
        int                bpCycles;
        bit                restart;
        logic [3:0][63:0]  expWr;
        logic [3:0][9:0]   expAddr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Slave configuration, set by the stimulus task per job.
    int stallCycles = 0;
    int pollsNeed   = 1;
    int neverCmd    = 0;

    // Slave state.
    int         stallCnt = 0;
    int         slvReads = 0;
    logic [3:0] slvCmd   = 4'h0;

    // Monitor logs.
    logic [63:0] wrLog[$];
    logic [9:0]  rdLog[$];
    int          pollsSeen[16];
    logic [3:0]  monCmd = 4'h0;
    int          gapState = 0;
    int          bothViol = 0, pushReadViol = 0, stallViol = 0, gapViol = 0, addrViol = 0;
    logic        prevStall = 1'b0, prevRd = 1'b0, prevWr = 1'b0;
    logic [9:0]  prevAddr = '0;
    logic [63:0] prevData = '0;

    // Stimulus-side bookkeeping.
    logic [63:0] rowData[$];
    logic [7:0]  rowIdx[$];
    int          holdViol = 0;
    int          doneCount = 0;
    int          wrBase = 0, rdBase = 0, violBase = 0;

    vec_t vecs[6];

    assign master_waitrequest = (master_read || master_write) && (stallCnt < stallCycles);

    // Slave read data: row space returns a tag plus the address, control space
    // returns the done bit of the last command once enough polls have occurred.
    always_comb begin
        master_readdata = '0;
        if (master_address[9:8] == 2'b11) begin
            master_readdata = 64'hC0DE_0000_0000_0000 | {54'h0, master_address};
        end else if (master_address == 10'h000 && slvCmd >= 4'd1 && slvCmd <= 4'd3 &&
                     int'(slvCmd) != neverCmd && (slvReads + 1) >= pollsNeed) begin
            master_readdata = 64'd1 << (slvCmd - 4'd1);
        end
    end

    // Slave sequential state: stall counter and per-command status read count.
    always @(posedge clk) begin
        if ((master_read || master_write) && master_waitrequest) stallCnt <= stallCnt + 1;
        else stallCnt <= 0;
        if (master_write && !master_waitrequest) begin
            slvCmd   <= master_writedata[3:0];
            slvReads <= 0;
        end else if (master_read && !master_waitrequest && master_address == 10'h000) begin
            slvReads <= slvReads + 1;
        end
    end

    // Bus monitor: logs completed transfers and counts protocol violations.
    always @(negedge clk) begin
        if (gapState == 1) begin
            if (master_read) gapViol++;
            gapState = 2;
        end else if (gapState == 2) begin
            if (busy && !master_read) gapViol++;
            gapState = 0;
        end
        if (master_read && master_write) bothViol++;
        if (master_read && out_valid) pushReadViol++;
        if (prevStall && (master_address !== prevAddr || master_writedata !== prevData ||
                          master_read !== prevRd || master_write !== prevWr)) stallViol++;
        prevStall = (master_read || master_write) && master_waitrequest;
        prevAddr  = master_address;
        prevData  = master_writedata;
        prevRd    = master_read;
        prevWr    = master_write;
        if (master_write && !master_waitrequest) begin
            wrLog.push_back(master_writedata);
            if (master_address != 10'h000) addrViol++;
            monCmd = master_writedata[3:0];
            if (master_writedata == 64'hF) begin
                for (int i = 0; i < 16; i++) pollsSeen[i] = 0;
            end
        end
        if (master_read && !master_waitrequest) begin
            if (master_address[9:8] == 2'b11) begin
                rdLog.push_back(master_address);
            end else if (master_address == 10'h000) begin
                pollsSeen[monCmd]++;
                if (master_readdata == 64'h0) gapState = 1;
            end else begin
                addrViol++;
            end
        end
    end

    function automatic int violSum();
        return bothViol + pushReadViol + stallViol + gapViol + addrViol + holdViol;
    endfunction

    function automatic vec_t mkVec(input logic [7:0] wb, ib, ob, input logic [8:0] nr,
                                   input int stall, polls, bpRow, bpCycles, input bit restart,
                                   input logic [63:0] wFill, wMul,
                                   input logic [9:0] a0, a1, a2, a3);
        vec_t v;
        v          = '0;
        v.wb       = wb;
        v.ib       = ib;
        v.ob       = ob;
        v.nr       = nr;
        v.stall    = stall;
        v.polls    = polls;
        v.bpRow    = bpRow;
        v.bpCycles = bpCycles;
        v.restart  = restart;
        v.expWr[0] = 64'hF;
        v.expWr[1] = wFill;
        v.expWr[2] = 64'h2;
        v.expWr[3] = wMul;
        v.expAddr[0] = a0;
        v.expAddr[1] = a1;
        v.expAddr[2] = a2;
        v.expAddr[3] = a3;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int never);
        int  holdCnt;
        bit  finished;
        bit  prevHold;
        logic [63:0] heldData;
        logic [7:0]  heldRow;
        stallCycles = v.stall;
        pollsNeed   = v.polls;
        neverCmd    = never;
        wrBase      = wrLog.size();
        rdBase      = rdLog.size();
        violBase    = violSum();
        rowData.delete();
        rowIdx.delete();
        doneCount   = 0;
        holdCnt     = 0;
        finished    = 0;
        prevHold    = 0;
        heldData    = '0;
        heldRow     = '0;
        weight_base = v.wb;
        input_base  = v.ib;
        output_base = v.ob;
        num_rows    = v.nr;
        out_ready   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("busyAfterStart", busy, 1'b1);
        checkVal("errorClearedAtStart", error, 1'b0);
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (prevHold && (out_valid !== 1'b1 || out_data !== heldData || out_row !== heldRow))
                holdViol++;
            if (done) doneCount++;
            if (doneCount > 0 && !busy) finished = 1;
            start = (v.restart && cyc == 20) ? 1'b1 : 1'b0;
            if (out_valid) begin
                if (out_row == v.bpRow[7:0] && holdCnt < v.bpCycles) begin
                    out_ready = 1'b0;
                    holdCnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            if (out_valid && out_ready) begin
                rowData.push_back(out_data);
                rowIdx.push_back(out_row);
            end
            prevHold = out_valid && !out_ready;
            heldData = out_data;
            heldRow  = out_row;
            if (!finished) @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL jobTimeout: busy=%0b done count=%0d after 4000 cycles", busy, doneCount);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int expNumWr, input int expRows,
                               input logic expErr, input int pFill, pDrain, pMul);
        int nWr;
        int nRd;
        nWr = wrLog.size() - wrBase;
        nRd = rdLog.size() - rdBase;
        checkVal("writeCount", nWr, expNumWr);
        for (int i = 0; i < expNumWr && i < nWr; i++)
            checkVal($sformatf("writeData%0d", i), wrLog[wrBase + i], v.expWr[i]);
        checkVal("rowReadCount", nRd, expRows);
        for (int i = 0; i < expRows && i < nRd; i++)
            checkVal($sformatf("rowAddr%0d", i), rdLog[rdBase + i], v.expAddr[i]);
        checkVal("streamedRows", rowData.size(), expRows);
        for (int i = 0; i < expRows && i < rowData.size(); i++) begin
            checkVal($sformatf("rowData%0d", i), rowData[i],
                     64'hC0DE_0000_0000_0000 | {54'h0, v.expAddr[i]});
            checkVal($sformatf("rowIndex%0d", i), rowIdx[i], i);
        end
        checkVal("pollsFill", pollsSeen[1], pFill);
        checkVal("pollsDrain", pollsSeen[2], pDrain);
        checkVal("pollsMul", pollsSeen[3], pMul);
        checkVal("protocolViolations", violSum() - violBase, 0);
        checkVal("donePulses", doneCount, 1);
        checkVal("errorFlag", error, expErr);
        checkVal("busyAtEnd", busy, 1'b0);
    endtask

    initial begin
        //              wb     ib     ob     nr  stl pol bpR bpC rs  fillCmd      mulCmd        addresses
        vecs[0] = mkVec(8'h10, 8'h20, 8'h30, 9'd4, 0, 1, 0, 0, 0, 64'h101, 64'h30203, 10'h330, 10'h331, 10'h332, 10'h333);
        vecs[1] = mkVec(8'h10, 8'h20, 8'h30, 9'd2, 3, 1, 0, 0, 1, 64'h101, 64'h30203, 10'h330, 10'h331, 10'h000, 10'h000);
        vecs[2] = mkVec(8'h10, 8'h20, 8'h30, 9'd1, 0, 5, 0, 0, 0, 64'h101, 64'h30203, 10'h330, 10'h000, 10'h000, 10'h000);
        vecs[3] = mkVec(8'h10, 8'h20, 8'hFE, 9'd3, 0, 1, 1, 4, 0, 64'h101, 64'hFE203, 10'h3FE, 10'h3FF, 10'h300, 10'h000);
        vecs[4] = mkVec(8'h10, 8'h20, 8'h30, 9'd0, 0, 1, 0, 0, 0, 64'h101, 64'h30203, 10'h000, 10'h000, 10'h000, 10'h000);
        vecs[5] = mkVec(8'hAB, 8'hCD, 8'h01, 9'd2, 1, 2, 0, 2, 0, 64'hAB1, 64'h01CD3, 10'h301, 10'h302, 10'h000, 10'h000);

        reset       = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        weight_base = '0;
        input_base  = '0;
        output_base = '0;
        num_rows    = '0;
        repeat (2) @(negedge clk);
        checkVal("rstBusy", busy, 1'b0);
        checkVal("rstDone", done, 1'b0);
        checkVal("rstError", error, 1'b0);
        checkVal("rstRead", master_read, 1'b0);
        checkVal("rstWrite", master_write, 1'b0);
        checkVal("rstAddress", master_address, 10'h000);
        checkVal("rstWritedata", master_writedata, 64'h0);
        checkVal("rstByteenable", master_byteenable, 8'hFF);
        checkVal("rstOutValid", out_valid, 1'b0);
        checkVal("rstOutData", out_data, 64'h0);
        checkVal("rstOutRow", out_row, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i], 0);
            checkOutput(vecs[i], 4, int'(vecs[i].nr), 1'b0,
                        vecs[i].polls, vecs[i].polls, vecs[i].polls);
            repeat (2) @(negedge clk);
        end

`ifdef SEQ_TIMEOUT_EN
        $display("[TB] drain done bit never set");
        applyStimulus(vecs[0], 2);
        checkOutput(vecs[0], 3, 0, 1'b1, 1, TP, 0);
        repeat (2) @(negedge clk);
        applyStimulus(vecs[0], 0);
        checkOutput(vecs[0], 4, 4, 1'b0, 1, 1, 1);
        repeat (2) @(negedge clk);
`endif

        $display("[TB] reset during drain polling");
        begin
            bit found;
            found       = 0;
            stallCycles = 0;
            pollsNeed   = 4;
            neverCmd    = 0;
            weight_base = 8'h10;
            input_base  = 8'h20;
            output_base = 8'h30;
            num_rows    = 9'd4;
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 500 && !found; cyc++) begin
                @(negedge clk);
                if (master_read && master_address == 10'h000 && monCmd == 4'h2) found = 1;
            end
            checkVal("reachedPollDrain", found, 1'b1);
            #2 reset = 1'b1;
            #1;
            checkVal("midRstBusy", busy, 1'b0);
            checkVal("midRstRead", master_read, 1'b0);
            checkVal("midRstWrite", master_write, 1'b0);
            checkVal("midRstAddress", master_address, 10'h000);
            checkVal("midRstOutValid", out_valid, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
        applyStimulus(vecs[0], 0);
        checkOutput(vecs[0], 4, 4, 1'b0, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
